// File: rtl/muxn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muxn_pkg
// Brief    : Shared constants and helpers for the arbitrating N:1 mux.
// Revision : 1.0
// ============================================================================
package muxn_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Ceiling log2 usable in parameter defaults; returns at least 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin or fixed-priority arbiter owning the search pointer.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter int N     = 4,
    parameter int MODE  = MODE_RR,
    parameter int SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W:0]   base;
    logic [SEL_W:0]   cand;
    logic             found;

    assign base = (MODE == MODE_RR) ? {1'b0, ptr_q} : '0;

    // Walk base, base+1, ... with wrap at N so indices >= N are never visited.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int j = 0; j < N; j++) begin
            cand = base + (SEL_W+1)'(j);
            if (cand >= (SEL_W+1)'(N)) begin
                cand = cand - (SEL_W+1)'(N);
            end
            if (!found && req[cand[SEL_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[SEL_W-1:0]]   = 1'b1;
                grant_idx                = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((MODE == MODE_RR) && advance && found) begin
            ptr_d = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/muxn_rr_reg.sv
`default_nettype none
// ============================================================================
// Module   : muxn_rr_reg
// Brief    : N-channel arbitrating mux with a single registered output stage.
// Revision : 1.0
// ============================================================================
module muxn_rr_reg
    import muxn_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int MODE  = MODE_RR,
    parameter int SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    logic             load;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;

    logic             valid_q;
    logic             valid_d;
    logic [W-1:0]     data_q;
    logic [W-1:0]     data_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    // Empty register or a draining one can accept a new beat in the same cycle.
    assign load     = ~valid_q | out_ready;
    assign in_ready = grant & {N{load & ~rst}};

    rr_arbiter #(
        .N     (N),
        .MODE  (MODE),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (load) begin
            valid_d = |in_valid;
            if (|in_valid) begin
                data_d = in_data[int'(grant_idx)*W +: W];
                sel_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_muxn_rr_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_muxn_rr_reg
// Brief    : Three instances (RR N=4, fixed N=4, RR N=3) against a queue-free reference model.
// Revision : 1.0
// ============================================================================
module tb_muxn_rr_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  iv   [3];
    logic [31:0] id   [3];
    logic        ordy [3];

    logic [3:0]  ir0, ir1;
    logic [2:0]  ir2;
    logic        ov0, ov1, ov2;
    logic [7:0]  od0, od1, od2;
    logic [1:0]  os0, os1, os2;

    int n_chk = 0;
    int n_err = 0;

    int NN [3] = '{4, 4, 3};
    int MM [3] = '{0, 1, 0};

    logic       m_ov  [3];
    logic [7:0] m_od  [3];
    int         m_os  [3];
    int         m_ptr [3];

    always #5 clk = ~clk;

    muxn_rr_reg #(.N(4), .W(8), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy[0]));

    muxn_rr_reg #(.N(4), .W(8), .MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy[1]));

    muxn_rr_reg #(.N(3), .W(8), .MODE(0)) dut_odd (
        .clk(clk), .rst(rst), .in_valid(iv[2][2:0]), .in_data(id[2][23:0]), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy[2]));

    function automatic logic [3:0] get_ir(int k);
        case (k)
            0:       return ir0;
            1:       return ir1;
            default: return {1'b0, ir2};
        endcase
    endfunction

    function automatic logic get_ov(int k);
        case (k)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [7:0] get_od(int k);
        case (k)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

    function automatic logic [1:0] get_os(int k);
        case (k)
            0:       return os0;
            1:       return os1;
            default: return os2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Winner by the arbitration rule: scan from ptr with wrap, or lowest index.
    function automatic int ref_grant(int k);
        int c;
        if (MM[k] == 1) begin
            for (int i = 0; i < NN[k]; i++) begin
                if (iv[k][i]) return i;
            end
            return -1;
        end
        for (int j = 0; j < NN[k]; j++) begin
            c = (m_ptr[k] + j) % NN[k];
            if (iv[k][c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] ref_ready(int k);
        int g;
        if (rst) return 4'b0000;
        g = ref_grant(k);
        if (g >= 0 && (!m_ov[k] || ordy[k])) return 4'(1 << g);
        return 4'b0000;
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready[%0d]", k),  32'(get_ir(k)), 32'(ref_ready(k)));
            chk($sformatf("out_valid[%0d]", k), 32'(get_ov(k)), 32'(m_ov[k]));
            chk($sformatf("out_data[%0d]", k),  32'(get_od(k)), 32'(m_od[k]));
            chk($sformatf("out_sel[%0d]", k),   32'(get_os(k)), 32'(m_os[k]));
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit load;
            int g;
            load = !m_ov[k] || ordy[k];
            g    = ref_grant(k);
            if (load) begin
                if (g >= 0) begin
                    m_ov[k] = 1'b1;
                    m_od[k] = id[k][g*8 +: 8];
                    m_os[k] = g;
                    if (MM[k] == 0) m_ptr[k] = (g + 1) % NN[k];
                end else begin
                    m_ov[k] = 1'b0;
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = 1'b0; m_od[k] = '0; m_os[k] = 0; m_ptr[k] = 0;
        end
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; id[k] = '0; ordy[k] = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] held_d;
        logic [1:0] held_s;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Single channel on ch2
        iv[0] = 4'b0100; id[0] = 32'h003C_0000; ordy[0] = 1'b1;
        #1 chk("single_ready", 32'(ir0), 32'h4);
        tick();
        chk("single_valid", 32'(ov0), 32'h1);
        chk("single_data",  32'(od0), 32'h3C);
        chk("single_sel",   32'(os0), 32'h2);
        iv[0] = '0;
        tick();

        // Fairness on RR instance, fixed priority on the other
        do_reset();
        iv[0] = 4'hF; iv[1] = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            id[0] = $urandom; id[1] = $urandom;
            tick();
            chk("rr_sel",   32'(os0), 32'(c % 4));
            chk("rr_valid", 32'(ov0), 32'h1);
            chk("fp_sel",   32'(os1), 32'h1);
        end

        // Back-pressure on the RR instance holding sel 3
        ordy[0] = 1'b0;
        held_d  = od0;
        held_s  = os0;
        for (int c = 0; c < 3; c++) begin
            id[0] = $urandom;
            #1 chk("stall_ready", 32'(ir0), 32'h0);
            tick();
            chk("stall_data",  32'(od0), 32'(held_d));
            chk("stall_sel",   32'(os0), 32'(held_s));
            chk("stall_valid", 32'(ov0), 32'h1);
        end
        ordy[0] = 1'b1;
        tick();
        chk("release_sel", 32'(os0), 32'h0);
        idle_inputs();
        tick();

        // Odd N wrap: move ptr to 2, then channels 0 and 2 contend
        do_reset();
        iv[2] = 4'b0010; id[2] = 32'h00AA_BBCC;
        tick();
        chk("odd_first", 32'(os2), 32'h1);
        iv[2] = 4'b0101;
        tick();
        chk("odd_wrap_a", 32'(os2), 32'h2);
        chk("odd_data_a", 32'(od2), 32'hAA);
        tick();
        chk("odd_wrap_b", 32'(os2), 32'h0);
        chk("odd_data_b", 32'(od2), 32'hCC);
        idle_inputs();
        tick();

        // Randomized traffic with stalls and withdrawn requests
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k]   = 4'($urandom) & ((NN[k] == 3) ? 4'h7 : 4'hF);
                id[k]   = $urandom;
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
            chk("odd_sel_range", 32'(os2 < 2'd3), 32'h1);
        end

        // Async reset during a stall with A5 in the register
        do_reset();
        iv[0] = 4'b0001; id[0] = 32'h0000_00A5; ordy[0] = 1'b0;
        tick();
        chk("pre_rst_data", 32'(od0), 32'hA5);
        tick();
        do_reset();
        chk("rst_valid", 32'(ov0), 32'h0);
        chk("rst_data",  32'(od0), 32'h0);
        chk("rst_sel",   32'(os0), 32'h0);
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
